// File: rtl/pe_start_fifo_reader_if.sv
// Bundles the start-FIFO read side and the downstream PE start/ready/done
// handshake into one bus.
// master: the reader (pops the FIFO and drives the PE start request).
// slave:  the environment (the FIFO plus the PE).
interface pe_start_fifo_reader_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_empty_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  pe_ap_start;
    logic                  pe_ap_ready;
    logic                  pe_ap_done;
    logic [DATA_WIDTH-1:0] pe_token;

    modport master (
        input  if_empty_n,
        input  if_dout,
        input  pe_ap_ready,
        input  pe_ap_done,
        output if_read,
        output pe_ap_start,
        output pe_token
    );

    modport slave (
        output if_empty_n,
        output if_dout,
        output pe_ap_ready,
        output pe_ap_done,
        input  if_read,
        input  pe_ap_start,
        input  pe_token
    );
endinterface

// File: rtl/pe_start_fifo_reader.sv
// pe_start_fifo_reader
// Pops start tokens from a FIFO one at a time and hands each to a downstream
// PE through an ap_start/ap_ready/ap_done handshake. Only one token is ever
// outstanding. A done pulse that arrives when no start is pending or accepted
// is a protocol violation and sets the sticky error flag.
// Optional feature: define PE_START_FIFO_READER_CNT_EN to get free-running
// 32-bit start/done handshake counters; otherwise both read as constant 0.
module pe_start_fifo_reader #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    pe_start_fifo_reader_if.master         bus,
    output logic                           busy,
    output logic                           err_sticky,
    output logic [31:0]                    start_cnt,
    output logic [31:0]                    done_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    logic                  pe_ap_start_r;
    logic                  busy_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] token_r;

    // Pop is combinational so a token can be taken in the same cycle it appears;
    // gated by reset so nothing is popped while the block is held in reset.
    assign bus.if_read     = ap_rst_n && (state == IDLE) && bus.if_empty_n;
    assign bus.pe_ap_start = pe_ap_start_r;
    assign bus.pe_token    = token_r;
    assign busy            = busy_r;
    assign err_sticky      = err_r;

    // Main handshake FSM with registered start/busy/error outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            pe_ap_start_r <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
            token_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pe_ap_done) begin
                        err_r <= 1'b1;
                    end
                    if (bus.if_empty_n) begin
                        token_r       <= bus.if_dout;
                        state         <= START;
                        pe_ap_start_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end
                end
                START: begin
                    if (bus.pe_ap_ready) begin
                        pe_ap_start_r <= 1'b0;
                        if (bus.pe_ap_done) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end else if (bus.pe_ap_done) begin
                        err_r <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.pe_ap_done) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    pe_ap_start_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_START_FIFO_READER_CNT_EN
    logic [31:0] start_cnt_r;
    logic [31:0] done_cnt_r;
    logic        start_fire;
    logic        done_fire;

    assign start_fire = pe_ap_start_r && bus.pe_ap_ready;
    assign done_fire  = ((state == START) && bus.pe_ap_ready && bus.pe_ap_done) ||
                        ((state == WAIT_DONE) && bus.pe_ap_done);

    // Handshake counters; natural 32-bit wrap.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_cnt_r <= 32'd0;
            done_cnt_r  <= 32'd0;
        end else begin
            if (start_fire) begin
                start_cnt_r <= start_cnt_r + 32'd1;
            end
            if (done_fire) begin
                done_cnt_r <= done_cnt_r + 32'd1;
            end
        end
    end

    assign start_cnt = start_cnt_r;
    assign done_cnt  = done_cnt_r;
`else
    assign start_cnt = 32'd0;
    assign done_cnt  = 32'd0;
`endif

endmodule

// File: doc/pe_start_fifo_reader.md
PE_START_FIFO_READER -- requirements
Module: pe_start_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1: width of the start-token payload.
REQ-002 SHALL have port ap_clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port ap_rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port if_empty_n  input  1: high when the start FIFO head holds a valid token.
REQ-005 SHALL have port if_read  output  1: pops the FIFO head, one token per high cycle.
REQ-006 SHALL have port if_dout  input  DATA_WIDTH: payload at the FIFO head, valid while if_empty_n=1.
REQ-007 SHALL have port pe_ap_start  output  1: start request to the downstream PE.
REQ-008 SHALL have port pe_ap_ready  input  1: PE has accepted the start.
REQ-009 SHALL have port pe_ap_done  input  1: PE has finished the current task (one-cycle pulse).
REQ-010 SHALL have port pe_token  output  DATA_WIDTH: payload of the token being served.
REQ-011 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-012 SHALL have port err_sticky  output  1: set by a protocol violation; cleared only by reset.
REQ-013 SHALL have ports start_cnt and done_cnt  output  32 each: handshake counters (REQ-027).

Function
REQ-014 SHALL implement FSM states IDLE, START and WAIT_DONE, with exactly one token outstanding at a time.
REQ-015 In IDLE with if_empty_n=1, if_read SHALL be 1 combinationally, if_dout SHALL be latched into pe_token, and the FSM SHALL enter START at the next edge.
REQ-016 if_read SHALL be 0 in every state other than IDLE, and SHALL be 0 whenever if_empty_n=0.
REQ-017 pe_ap_start SHALL be 1 only in START, so it rises exactly one cycle after the pop.
REQ-018 In START with pe_ap_ready=1 and pe_ap_done=0, the FSM SHALL go to WAIT_DONE.
REQ-019 In START with pe_ap_ready=1 and pe_ap_done=1, the FSM SHALL go directly to IDLE.
REQ-020 In START with pe_ap_ready=0, the FSM SHALL hold and pe_ap_start SHALL stay high; pe_ap_done there SHALL set err_sticky.
REQ-021 In WAIT_DONE with pe_ap_done=1, the FSM SHALL go to IDLE; pe_ap_ready there SHALL be ignored.
REQ-022 pe_ap_done in IDLE SHALL set err_sticky and SHALL cause no state change.
REQ-023 pe_token SHALL hold its value until the next pop.
REQ-024 Throughput: back-to-back tokens through a zero-latency PE (ready and done in the same cycle) SHALL yield one pop every 2 cycles.

Reset
REQ-025 While ap_rst_n=0: state IDLE; if_read, pe_ap_start, busy, err_sticky, pe_token, start_cnt and done_cnt all 0.
REQ-026 Reset during START or WAIT_DONE SHALL discard the in-flight token with no re-pop; operation SHALL resume from IDLE at the first edge after deassertion.

Configuration
REQ-027 With macro PE_START_FIFO_READER_CNT_EN defined: start_cnt SHALL increment on each cycle with pe_ap_start=1 and pe_ap_ready=1, and done_cnt on each done accepted per REQ-019/REQ-021; both SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 With PE_START_FIFO_READER_CNT_EN undefined: start_cnt and done_cnt SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset released, if_empty_n=1, if_dout=1, PE ready after 3 cycles and done 5 cycles later -> if_read high 1 cycle, pe_ap_start high 4 cycles, pe_token=1, busy low after the done.
REQ-030 4 tokens queued, PE ready=done=1 every cycle -> if_read pulses on cycles 0, 2, 4, 6; with the macro defined, start_cnt=done_cnt=4.
REQ-031 pe_ap_done pulsed in IDLE, then a normal token -> err_sticky=1 and stays 1; the token is still served normally.
REQ-032 ap_rst_n asserted in WAIT_DONE -> all outputs 0 immediately (asynchronous); no extra if_read after release while if_empty_n=0.
REQ-033 Macro defined, counters preset to 0xFFFFFFFF via forced state, one full handshake -> start_cnt=0 and done_cnt=0.
REQ-034 Macro undefined, same stimulus as REQ-030 -> start_cnt=done_cnt=0 and an identical if_read/pe_ap_start trace.
